smem_ctrl: RTL
==============

// Module: smem_ctrl
// PURPOSE
//  Store path of the MEM stage: the write-side counterpart of the load-data extractor. Turns
//  SB/SH/SW from MEM into a big-endian byte-strobed write on the data sram-like bus.
//  Checks alignment (AdES), holds request fields stable and stalls the pipeline until the
//  bus acknowledges address and data. Sits between the MEM-stage regs and the data bus arbiter.
// PARAMETERS
//  AW   32  address width
//  DW   32  data width (fixed 32; strobe logic assumes 4 byte lanes)
// PORTS
//  clk            in   1   single clock; all state on posedge
//  rst            in   1   synchronous, active-high reset
//  memwriteM      in   1   MEM-stage instruction is a store
//  alucontrolM    in   6   `SB_CONTROL / `SH_CONTROL / `SW_CONTROL (defines2.vh)
//  aluoutM        in   32  effective address
//  writedataM     in   32  rt value; low byte/half used for SB/SH
//  flushM         in   1   exception/flush in MEM; cancels a not-yet-accepted store
//  stallM         out  1   hold IF..MEM while a store is in flight
//  saddrerrM      out  1   store address error (combinational)
//  badvaddrM      out  32  faulting address (= aluoutM when saddrerrM)
//  data_req       out  1   bus request
//  data_wr        out  1   1 = write (always 1 when data_req)
//  data_size      out  2   0 byte, 1 half, 2 word
//  data_addr      out  32  latched address
//  data_wstrb     out  4   byte enables, bit3 = bits[31:24]
//  data_wdata     out  32  lane-replicated store data
//  data_addr_ok   in   1   address accepted this cycle
//  data_data_ok   in   1   write completed this cycle
// BEHAVIOUR
//  Lane map (big-endian, addr[1:0]=00 -> [31:24]):
//   SB: wstrb = 4'b1000 >> addr[1:0]; wdata = {4{wd[7:0]}}
//   SH: addr[1]=0 -> 4'b1100, addr[1]=1 -> 4'b0011; wdata = {2{wd[15:0]}}
//   SW: wstrb = 4'b1111; wdata = wd
//  Misalign: SH & addr[0], or SW & addr[1:0]!=0 -> saddrerrM=1, badvaddrM=aluoutM, no request.
//  saddrerrM is 0 whenever memwriteM=0 or alucontrolM is not a store code.
//  FSM IDLE -> REQ -> WAIT -> DONE -> IDLE:
//   IDLE: go = memwriteM & store code & ~saddrerrM & ~flushM. On go latch addr/size/
//    wstrb/wdata, -> REQ. stallM = go (combinational, same cycle).
//   REQ: data_req=1, fields stable. addr_ok&data_ok -> DONE; addr_ok only -> WAIT.
//   WAIT: data_req=0; data_ok -> DONE. data_ok seen before addr_ok is ignored.
//   DONE: stallM=0 for one cycle (pipeline advances), -> IDLE; no new store accepted in DONE.
//   stallM = 1 in REQ and WAIT.
//  flushM in REQ/WAIT is ignored: an issued request always completes (bus cannot abort).
//  Outputs held at 0 in IDLE/DONE except combinational stallM/saddrerrM/badvaddrM.
//  Reset (any state, incl. mid-transaction): state=IDLE, data_req=0, latched fields=0;
//   external bus must tolerate abandoned request.
//  Latency: min 3 cycles store accept -> pipeline release (IDLE, REQ w/ both oks, DONE).
// STRUCTURE
//  Store codes and size encodings (SIZE_B/H/W) live in defines2.vh, shared with lmem/alu.
//  Sub-module smem_align: pure combinational {alucontrol, addr[1:0], wd} -> {size, wstrb,
//   wdata, misalign}; reused by a later write-buffer. FSM + latch regs in smem_ctrl.
// TESTING
//  SB addr 0x1003, wd 0x000000A5, addr_ok=data_ok=1 at REQ -> wstrb 0001, wdata A5A5A5A5,
//   size 0, stallM high 2 cycles then low.
//  SH addr 0x1002, wd 0x1234 -> wstrb 0011, wdata 12341234; SH addr 0x1000 -> 1100.
//  SW addr 0x1001 -> saddrerrM=1, badvaddrM=0x1001, data_req never asserts, stallM=0.
//  SW addr 0x2000, addr_ok at cycle+2, data_ok at cycle+5 -> data_req high exactly until
//   addr_ok, fields stable, stallM drops the cycle after data_ok.
//  flushM with SW in IDLE -> no request; flushM asserted in WAIT -> transaction completes.
//  rst pulsed in WAIT -> next cycle IDLE, data_req=0, stallM=0; following SB issues cleanly.

Source files
------------

// File: rtl/smem_ctrl_pkg.sv
// Shared encodings for the MEM-stage store path: store op codes, bus size codes,
// controller states and the latched write-request record.
package smem_ctrl_pkg;

    localparam logic [5:0] SB_CONTROL = 6'b101000;
    localparam logic [5:0] SH_CONTROL = 6'b101001;
    localparam logic [5:0] SW_CONTROL = 6'b101011;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } smem_state_e;

    typedef struct packed {
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } smem_wreq_t;

    function automatic logic is_store_code(input logic [5:0] ctrl);
        return (ctrl == SB_CONTROL) || (ctrl == SH_CONTROL) || (ctrl == SW_CONTROL);
    endfunction

endpackage

// File: rtl/smem_align.sv
// Store lane aligner: maps a store op, the low address bits and rt onto a big-endian
// byte-strobed 32-bit write, and flags misaligned halfword/word stores.
module smem_align
    import smem_ctrl_pkg::*;
(
    input  logic [5:0]  alucontrol_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wd_i,
    output logic        is_store_o,
    output smem_wreq_t  wreq_o,
    output logic        misalign_o
);

    always_comb begin
        wreq_o     = '0;
        misalign_o = 1'b0;
        is_store_o = is_store_code(alucontrol_i);
        case (alucontrol_i)
            SB_CONTROL: begin
                wreq_o.size  = SIZE_B;
                wreq_o.wstrb = 4'b1000 >> addr_lo_i;
                wreq_o.wdata = {4{wd_i[7:0]}};
            end
            SH_CONTROL: begin
                wreq_o.size  = SIZE_H;
                wreq_o.wstrb = addr_lo_i[1] ? 4'b0011 : 4'b1100;
                wreq_o.wdata = {2{wd_i[15:0]}};
                misalign_o   = addr_lo_i[0];
            end
            SW_CONTROL: begin
                wreq_o.size  = SIZE_W;
                wreq_o.wstrb = 4'b1111;
                wreq_o.wdata = wd_i;
                misalign_o   = |addr_lo_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/smem_ctrl.sv
// MEM-stage store controller: issues one write per store on the sram-like data bus and
// stalls the pipeline until the bus has accepted both address and data.
//
// state | meaning
// IDLE  | nothing in flight; a valid, unflushed store is latched and issued
// REQ   | data_req high with latched fields, waiting for addr_ok
// WAIT  | address taken, waiting for data_ok
// DONE  | one-cycle pipeline release; no new store accepted here
module smem_ctrl
    import smem_ctrl_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          memwriteM,
    input  logic [5:0]    alucontrolM,
    input  logic [AW-1:0] aluoutM,
    input  logic [DW-1:0] writedataM,
    input  logic          flushM,
    output logic          stallM,
    output logic          saddrerrM,
    output logic [AW-1:0] badvaddrM,
    output logic          data_req,
    output logic          data_wr,
    output logic [1:0]    data_size,
    output logic [AW-1:0] data_addr,
    output logic [3:0]    data_wstrb,
    output logic [DW-1:0] data_wdata,
    input  logic          data_addr_ok,
    input  logic          data_data_ok
);

    smem_state_e   state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    smem_wreq_t    wreq_q, wreq_d;

    smem_wreq_t    align_wreq;
    logic          align_is_store;
    logic          align_misalign;
    logic          store_valid;
    logic          go;
    logic          in_flight;

    smem_align u_align (
        .alucontrol_i (alucontrolM),
        .addr_lo_i    (aluoutM[1:0]),
        .wd_i         (writedataM),
        .is_store_o   (align_is_store),
        .wreq_o       (align_wreq),
        .misalign_o   (align_misalign)
    );

    assign store_valid = memwriteM & align_is_store;
    assign saddrerrM   = store_valid & align_misalign;
    assign badvaddrM   = saddrerrM ? aluoutM : '0;
    assign go          = store_valid & ~align_misalign & ~flushM;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wreq_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wreq_q  <= wreq_d;
        end
    end

    // Once issued, a request runs to completion: the bus has no abort, so flushM is
    // only honoured before acceptance.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wreq_d  = wreq_q;
        stallM  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (go) begin
                    stallM  = 1'b1;
                    addr_d  = aluoutM;
                    wreq_d  = align_wreq;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                stallM = 1'b1;
                if (data_addr_ok) begin
                    state_d = data_data_ok ? ST_DONE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                stallM = 1'b1;
                if (data_data_ok) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign in_flight  = (state_q == ST_REQ) || (state_q == ST_WAIT);
    assign data_req   = (state_q == ST_REQ);
    assign data_wr    = data_req;
    assign data_size  = in_flight ? wreq_q.size  : 2'd0;
    assign data_addr  = in_flight ? addr_q       : '0;
    assign data_wstrb = in_flight ? wreq_q.wstrb : 4'd0;
    assign data_wdata = in_flight ? wreq_q.wdata : '0;

endmodule
